imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values are 32 and 64.
REQ-002 Parameter TAGW, default 4, width of the sideband tag carried alongside each instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  upstream holds a valid instruction.
REQ-007 in_ready  output  1  block accepts an input this cycle.
REQ-008 ir2  input  32  instruction word.
REQ-009 sext_select  input  3  immediate format select.
REQ-010 in_tag  input  TAGW  sideband tag, passed through unchanged.
REQ-011 out_valid  output  1  out_imm, out_tag and out_err are valid.
REQ-012 out_ready  input  1  downstream accepts the output this cycle.
REQ-013 out_imm  output  XLEN  extended immediate.
REQ-014 out_tag  output  TAGW  tag of the presented entry.
REQ-015 out_err  output  1  the entry had an unsupported select.

Function
REQ-016 Formats SHALL be: 0 I {ir2[31:20]} sign-ext; 1 B {ir2[31],ir2[7],ir2[30:25],ir2[11:8],0} sign-ext; 2 U {ir2[31:12],12'b0} sign-ext; 3 S {ir2[31:25],ir2[11:7]} sign-ext; 4 J {ir2[31],ir2[19:12],ir2[20],ir2[30:21],0} sign-ext.
REQ-017 Sign extension SHALL be from ir2[31] to the full XLEN; U-type SHALL therefore fill bits XLEN-1:32 with ir2[31] when XLEN=64.
REQ-018 Select 5 (CSR zimm) SHALL zero-extend ir2[19:15].
REQ-019 Select 6 (shamt) SHALL zero-extend ir2[24:20] when XLEN=32 and ir2[25:20] when XLEN=64.
REQ-020 Select 7 SHALL produce out_imm=0 with out_err=1; all other selects SHALL set out_err=0.
REQ-021 An input SHALL transfer when in_valid and in_ready are both high; an output SHALL transfer when out_valid and out_ready are both high.
REQ-022 Latency SHALL be exactly one cycle: an input accepted at edge N is presented at out_valid after edge N when the output stage is empty or draining.
REQ-023 Storage SHALL be a 2-entry skid buffer (output register plus skid register); in_ready SHALL be a register output, equal to NOT skid_valid.
REQ-024 When out_valid=1, out_ready=0 and an input is accepted, the input SHALL be captured in the skid register and in_ready SHALL drop on the next cycle.
REQ-025 When the output transfers while the skid register is full, the skid entry SHALL move to the output register and in_ready SHALL rise on the next cycle.
REQ-026 While out_valid=1 and out_ready=0, out_imm, out_tag and out_err SHALL hold stable.
REQ-027 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush or reset.
REQ-028 flush SHALL clear both valid bits at the next edge, override simultaneous input/output transfers, and leave in_ready=1.
REQ-029 In the same cycle, an output transfer and an input transfer SHALL both complete; occupancy SHALL be unchanged.

Reset
REQ-030 On reset, out_valid=0, skid_valid=0, in_ready=1, out_imm=0, out_tag=0 and out_err=0 SHALL be set; reset SHALL have priority over flush and all transfers.
REQ-031 Reset asserted mid-backpressure SHALL discard both entries with no output transfer.

Structure
REQ-032 Select encodings (SEL_I..SEL_ILL) and the shared opcode constants SHALL reside in the common decode package.
REQ-033 The combinational extender SHALL be a sub-module, imm_extend (ir2, sext_select -> imm, err; XLEN parameter), instantiated once ahead of the skid buffer.

Verification
REQ-034 XLEN=32, sel=0, ir2=0xFFF00093, out_ready=1 -> one cycle later out_imm=0xFFFFFFFF, out_err=0.
REQ-035 sel=1, ir2=0xFE000EE3 -> out_imm=0xFFFFFFFC; sel=2, ir2=0x12345037 -> out_imm=0x12345000.
REQ-036 XLEN=64, sel=2, ir2=0x80000037 -> out_imm=0xFFFFFFFF80000000; sel=6, ir2=0x03F01013 -> out_imm=63.
REQ-037 out_ready=0 with three back-to-back inputs tagged 1,2,3 -> tags 1,2 are accepted, in_ready=0 from the cycle after tag 2, tag 3 is held upstream; out_ready=1 then delivers tags 1,2,3 in order.
REQ-038 Buffer full, then flush and in_valid high in the same cycle -> out_valid=0 next cycle, in_ready=1, and the input from that cycle is discarded; sel=7 input -> out_imm=0, out_err=1.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - shared decode constants for the immediate generator
package imm_gen_pipe_pkg;

   typedef enum logic [2:0] {
      SEL_I     = 3'd0,
      SEL_B     = 3'd1,
      SEL_U     = 3'd2,
      SEL_S     = 3'd3,
      SEL_J     = 3'd4,
      SEL_CSR   = 3'd5,
      SEL_SHAMT = 3'd6,
      SEL_ILL   = 3'd7
   } sext_sel_e;

   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   function automatic logic sel_is_legal(input logic [2:0] sel);
      return sel != SEL_ILL;
   endfunction

endpackage

// File: rtl/imm_gen_pipe_extend.sv
// rtl/imm_gen_pipe_extend.sv - combinational immediate extraction and extension
module imm_extend
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     ir2,
   input  logic [2:0]      sext_select,
   output logic [XLEN-1:0] imm,
   output logic            err
);

   logic unused_opcode;
   assign unused_opcode = ^ir2[6:0];

   // Signed formats start from a full fill of ir2[31] and overwrite the low bits.
   always_comb begin
      imm = '0;
      err = 1'b0;
      case (sext_select)
         SEL_I: begin
            imm       = {XLEN{ir2[31]}};
            imm[11:0] = ir2[31:20];
         end
         SEL_B: begin
            imm       = {XLEN{ir2[31]}};
            imm[12:0] = {ir2[31], ir2[7], ir2[30:25], ir2[11:8], 1'b0};
         end
         SEL_U: begin
            imm       = {XLEN{ir2[31]}};
            imm[31:0] = {ir2[31:12], 12'b0};
         end
         SEL_S: begin
            imm       = {XLEN{ir2[31]}};
            imm[11:0] = {ir2[31:25], ir2[11:7]};
         end
         SEL_J: begin
            imm       = {XLEN{ir2[31]}};
            imm[20:0] = {ir2[31], ir2[19:12], ir2[20], ir2[30:21], 1'b0};
         end
         SEL_CSR: begin
            imm[4:0] = ir2[19:15];
         end
         SEL_SHAMT: begin
            imm[4:0] = ir2[24:20];
            if (XLEN == 64) begin
               imm[5] = ir2[25];
            end
         end
         default: begin
            err = !sel_is_legal(sext_select);
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate generator behind a two-entry skid buffer
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     ir2,
   input  logic [2:0]      sext_select,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [TAGW-1:0] out_tag,
   output logic            out_err
);

   logic [XLEN-1:0] ext_imm;
   logic            ext_err;

   imm_extend #(.XLEN(XLEN)) u_ext (
      .ir2         (ir2),
      .sext_select (sext_select),
      .imm         (ext_imm),
      .err         (ext_err)
   );

   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_imm_q, out_imm_d;
   logic [TAGW-1:0] out_tag_q, out_tag_d;
   logic            out_err_q, out_err_d;
   logic            skid_valid_q, skid_valid_d;
   logic [XLEN-1:0] skid_imm_q, skid_imm_d;
   logic [TAGW-1:0] skid_tag_q, skid_tag_d;
   logic            skid_err_q, skid_err_d;
   logic            in_ready_q, in_ready_d;
   logic            in_xfer, out_free;

   assign in_xfer  = in_valid && in_ready_q;
   assign out_free = !out_valid_q || out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_tag_d    = out_tag_q;
      out_err_d    = out_err_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_tag_d   = skid_tag_q;
      skid_err_d   = skid_err_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         // A full skid means in_ready is low, so no input competes with the refill.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_tag_d    = skid_tag_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
         end else if (in_xfer) begin
            out_valid_d = 1'b1;
            out_imm_d   = ext_imm;
            out_tag_d   = in_tag;
            out_err_d   = ext_err;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = ext_imm;
         skid_tag_d   = in_tag;
         skid_err_d   = ext_err;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_tag_q    <= '0;
         out_err_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_tag_q   <= '0;
         skid_err_q   <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_tag_q    <= out_tag_d;
         out_err_q    <= out_err_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_tag_q   <= skid_tag_d;
         skid_err_q   <= skid_err_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_imm   = out_imm_q;
   assign out_tag   = out_tag_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

   typedef struct {
      logic [63:0] imm;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] ir2 = '0;
   logic [2:0]  sel = '0;
   logic [3:0]  in_tag = '0;
   logic        out_ready = 1'b0;

   logic        in_ready_a, out_valid_a, out_err_a;
   logic [31:0] out_imm_a;
   logic [3:0]  out_tag_a;
   logic        in_ready_b, out_valid_b, out_err_b;
   logic [63:0] out_imm_b;
   logic [3:0]  out_tag_b;

   logic [63:0] exp32_v, exp64_v;
   logic        experr_v;

   exp_t q32[$];
   exp_t q64[$];
   int checks = 0;
   int errors = 0;

   imm_gen_pipe #(.XLEN(32), .TAGW(4)) dut32 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
      .ir2(ir2), .sext_select(sel), .in_tag(in_tag), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_imm(out_imm_a), .out_tag(out_tag_a), .out_err(out_err_a)
   );

   imm_gen_pipe #(.XLEN(64), .TAGW(4)) dut64 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .ir2(ir2), .sext_select(sel), .in_tag(in_tag), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_imm(out_imm_b), .out_tag(out_tag_b), .out_err(out_err_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: immediates as plain signed integers assembled from field weights.
   function automatic logic [63:0] ref_imm(input logic [31:0] ir, input int s, input int xlen);
      longint v;
      logic [63:0] r;
      case (s)
         0: v = longint'($signed(ir)) >>> 20;
         1: v = (ir[31] ? -64'sd4096 : 64'sd0) + longint'(ir[7]) * 2048
                + longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2;
         2: v = longint'($signed(ir & 32'hFFFFF000));
         3: v = (ir[31] ? -64'sd2048 : 64'sd0) + longint'(ir[30:25]) * 32 + longint'(ir[11:7]);
         4: v = (ir[31] ? -64'sd1048576 : 64'sd0) + longint'(ir[19:12]) * 4096
                + longint'(ir[20]) * 2048 + longint'(ir[30:21]) * 2;
         5: v = longint'(ir[19:15]);
         6: v = (xlen == 64) ? longint'(ir[25:20]) : longint'(ir[24:20]);
         default: v = 0;
      endcase
      r = v;
      if (xlen == 32) r[63:32] = '0;
      return r;
   endfunction

   task automatic set_in(input logic [31:0] ir, input logic [2:0] s, input logic [3:0] t);
      in_valid = 1'b1;
      ir2      = ir;
      sel      = s;
      in_tag   = t;
      exp32_v  = ref_imm(ir, int'(s), 32);
      exp64_v  = ref_imm(ir, int'(s), 64);
      experr_v = (s == 3'd7);
   endtask

   task automatic set_in_exp(input logic [31:0] ir, input logic [2:0] s, input logic [3:0] t,
                             input logic [63:0] e32, input logic [63:0] e64, input logic e_err);
      in_valid = 1'b1;
      ir2      = ir;
      sel      = s;
      in_tag   = t;
      exp32_v  = e32;
      exp64_v  = e64;
      experr_v = e_err;
   endtask

   // Holds the current input until accepted, then returns #1 after the accepting edge.
   task automatic wait_accept();
      int n = 0;
      forever begin
         @(negedge clk);
         if (in_ready_a) break;
         n++;
         if (n > 50) begin
            chk("accept_timeout", 64'd1, 64'd0);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((q32.size() != 0 || q64.size() != 0) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_q32", 64'(q32.size()), 64'd0);
      chk("drain_q64", 64'(q64.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (!reset && !flush && in_valid && in_ready_a) begin
         q32.push_back('{imm: exp32_v, tag: in_tag, err: experr_v});
         q64.push_back('{imm: exp64_v, tag: in_tag, err: experr_v});
      end
   end

   logic        hold_pending = 1'b0;
   logic [31:0] held_imm_a;
   logic [63:0] held_imm_b;
   logic [3:0]  held_tag_a;
   logic        held_err_a;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         q32.delete();
         q64.delete();
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            chk("hold_imm32", 64'(out_imm_a), 64'(held_imm_a));
            chk("hold_imm64", out_imm_b, held_imm_b);
            chk("hold_tag", 64'(out_tag_a), 64'(held_tag_a));
            chk("hold_err", 64'(out_err_a), 64'(held_err_a));
         end
         if (out_valid_a && out_ready) begin
            if (q32.size() == 0) chk("q32_unexpected_output", 64'd1, 64'd0);
            else begin
               e = q32.pop_front();
               chk("imm32", 64'(out_imm_a), e.imm);
               chk("tag32", 64'(out_tag_a), 64'(e.tag));
               chk("err32", 64'(out_err_a), 64'(e.err));
            end
         end
         if (out_valid_b && out_ready) begin
            if (q64.size() == 0) chk("q64_unexpected_output", 64'd1, 64'd0);
            else begin
               e = q64.pop_front();
               chk("imm64", out_imm_b, e.imm);
               chk("tag64", 64'(out_tag_b), 64'(e.tag));
               chk("err64", 64'(out_err_b), 64'(e.err));
            end
         end
         hold_pending = out_valid_a && !out_ready && !flush;
         held_imm_a   = out_imm_a;
         held_imm_b   = out_imm_b;
         held_tag_a   = out_tag_a;
         held_err_a   = out_err_a;
         if (flush) begin
            q32.delete();
            q64.delete();
         end
      end
   end

   initial begin
      logic acc;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid_a), 64'd0);
      chk("rst_in_ready", 64'(in_ready_a), 64'd1);
      chk("rst_out_imm32", 64'(out_imm_a), 64'd0);
      chk("rst_out_imm64", out_imm_b, 64'd0);
      chk("rst_out_tag", 64'(out_tag_a), 64'd0);
      chk("rst_out_err", 64'(out_err_a), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      out_ready = 1'b1;
      set_in_exp(32'hFFF00093, 3'd0, 4'd1, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
      wait_accept();
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_one_cycle", 64'(out_valid_a), 64'd1);
      @(posedge clk); #1;
      set_in_exp(32'hFE000EE3, 3'd1, 4'd2, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
      wait_accept();
      set_in_exp(32'h12345037, 3'd2, 4'd3, 64'h12345000, 64'h12345000, 1'b0);
      wait_accept();
      set_in_exp(32'h80000037, 3'd2, 4'd4, 64'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
      wait_accept();
      set_in_exp(32'h03F01013, 3'd6, 4'd5, 64'd31, 64'd63, 1'b0);
      wait_accept();
      drain();

      out_ready = 1'b0;
      set_in(32'h00A00513, 3'd0, 4'd1);
      wait_accept();
      set_in(32'hFE000EE3, 3'd1, 4'd2);
      wait_accept();
      set_in(32'h123450B7, 3'd2, 4'd3);
      @(negedge clk);
      chk("ready_drop", 64'(in_ready_a), 64'd0);
      chk("stall_tag", 64'(out_tag_a), 64'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("ready_rise", 64'(in_ready_a), 64'd1);
      chk("skid_moved_tag", 64'(out_tag_a), 64'd2);
      @(posedge clk); #1;
      drain();

      out_ready = 1'b0;
      set_in(32'hDEADBEEF, 3'd4, 4'd6);
      wait_accept();
      set_in(32'h0FF0F0F0, 3'd3, 4'd7);
      wait_accept();
      set_in(32'h11111111, 3'd0, 4'd8);
      flush = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid_a), 64'd0);
      chk("flush_in_ready", 64'(in_ready_a), 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("flush_discard", 64'(out_valid_a), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      set_in_exp(32'hFFFFFFFF, 3'd7, 4'd9, 64'd0, 64'd0, 1'b1);
      wait_accept();
      in_valid = 1'b0;
      @(negedge clk);
      chk("ill_err", 64'(out_err_a), 64'd1);
      chk("ill_imm", out_imm_b, 64'd0);
      drain();

      out_ready = 1'b0;
      set_in(32'h00100073, 3'd5, 4'd10);
      wait_accept();
      set_in(32'h40000013, 3'd6, 4'd11);
      wait_accept();
      in_valid  = 1'b0;
      reset     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_out_valid", 64'(out_valid_a), 64'd0);
      chk("rst_mid_in_ready", 64'(in_ready_a), 64'd1);
      @(posedge clk); #1;

      in_valid = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         acc = in_valid && in_ready_a && !flush;
         @(posedge clk); #1;
         if (!in_valid || acc || flush) begin
            if ($urandom_range(3) != 0)
               set_in($urandom, 3'($urandom_range(7)), 4'($urandom_range(15)));
            else
               in_valid = 1'b0;
         end
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(63) == 0);
      end
      flush = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
